vip_osd_ctrl: RTL and testbench
===============================

Name: vip_osd_ctrl

Overview:
- Configuration and RAM-load sequencer for vip_osd, in the pclk domain.
- Holds shadow copies of the OSD window and colour registers, which the host writes at any time, and commits them atomically on the next vsync rising edge so the overlay never tears mid-frame.
- Streams glyph bitmap words from a valid/ready source into the vip_osd RAM write port, optionally only during vertical blank; the osd_ram_clk of vip_osd is tied to pclk.

Parameters:
BITS, 8, pixel/colour width
WIDTH, 1280, active pixels per line
HEIGHT, 720, active lines per frame
OSD_RAM_ADDR_BITS, 9, OSD RAM address width
OSD_RAM_DATA_BITS, 32, OSD RAM word width
LOAD_IN_BLANK, 1, 1 = RAM writes only while in_vsync=1; 0 = ungated

Ports:
pclk  in  1  pixel clock, sole clock
rst  in  1  asynchronous, active-high reset
in_vsync  in  1  frame sync from DVP, high = vertical blank
cfg_wen  in  1  register write strobe
cfg_addr  in  3  register index
cfg_wdata  in  16  register write data
load_start  in  1  one-cycle pulse, begin RAM load
load_base  in  OSD_RAM_ADDR_BITS  first RAM address
load_len  in  OSD_RAM_ADDR_BITS+1  word count, 0 = no-op
s_valid  in  1  source word valid
s_data  in  OSD_RAM_DATA_BITS  source word
s_ready  out  1  word accepted when s_valid&s_ready
load_busy  out  1  loader active
load_done  out  1  one-cycle pulse, last word written
commit_pending  out  1  shadow awaiting vsync
osd_x  out  11  active window x
osd_y  out  10  active window y
osd_w  out  11  active window width
osd_h  out  10  active window height
color_fg  out  BITS  foreground colour
color_bg  out  BITS  background colour
osd_ram_wen  out  1  RAM write enable
osd_ram_addr  out  OSD_RAM_ADDR_BITS  RAM address
osd_ram_wdata  out  OSD_RAM_DATA_BITS  RAM data

Behaviour:
- Reset values:
  - All active and shadow registers are 0; enable is 0.
  - commit_pending=0, s_ready=0, load_busy=0, load_done=0.
  - osd_ram_wen=0, osd_ram_addr=0, osd_ram_wdata=0.
- Register map, written on cfg_wen and truncated to field width:
  - 0: x, 1: y, 2: w, 3: h, 4: fg, 5: bg.
  - 6: ctrl. Bit0 = enable (shadow). Bit1 = commit; writing 1 sets commit_pending, and the bit is not stored.
  - 7: ignored.
- Commit:
  - vsync rising edge detected from a 1-cycle registered copy of in_vsync.
  - On a rising edge with commit_pending=1, active registers load from shadow in the next cycle and commit_pending clears in that same cycle.
  - Latency: 2 pclk from the in_vsync 0->1 sample.
  - A cfg write in the commit cycle updates the shadow only; it takes effect at the following commit.
  - A commit write coinciding with the rising edge is taken at that edge.
- Clamp at commit, using 12-bit unsigned arithmetic:
  - if x >= WIDTH, w_act=0;
  - else if x+w > WIDTH, w_act = WIDTH-x;
  - same for y/h against HEIGHT.
  - If enable_shadow=0, w_act=0 and h_act=0 (OSD hidden); x/y/colours still commit.
- Loader FSM:
  - IDLE:
    - load_start with load_len!=0 -> LOAD; latch addr=load_base, remaining=load_len.
    - load_len=0 -> pulse load_done next cycle and stay IDLE.
  - LOAD:
    - load_busy=1.
    - s_ready = (LOAD_IN_BLANK ? in_vsync : 1).
    - Each accepted word registers osd_ram_wen=1, addr, and data on the next cycle, then increments addr and decrements remaining.
    - Address wraps modulo 2^OSD_RAM_ADDR_BITS.
    - On accepting the final word -> DONE.
  - DONE: load_done=1 for one cycle, load_busy=0, -> IDLE.
  - osd_ram_wen is 0 whenever no word was accepted in the previous cycle.
  - load_start while not IDLE is ignored.
  - s_ready falling mid-load, because vsync dropped, pauses the load; it resumes on the next blank with no loss or duplication.
- Reset asserted mid-load aborts immediately: outputs go to reset values and the partial RAM contents are left as-is.

Test Plan:
- Reset, then write x=100, y=100, w=128, h=32, fg=0xFF, bg=0x00, ctrl=0x3 with vsync low -> outputs stay 0 and commit_pending=1; in_vsync rises -> 2 cycles later osd_x=100, osd_w=128, osd_h=32, and commit_pending=0.
- Commit x=1200, w=128 -> osd_w=80; commit x=1280 -> osd_w=0; commit y=700, h=32 -> osd_h=20.
- ctrl=0x2 (enable=0) with w=128 -> after vsync osd_w=0, osd_h=0, osd_x updated.
- LOAD_IN_BLANK=1, load_base=0, load_len=129, source always valid with a 128-word glyph table plus one word:
  - writes occur only while in_vsync=1;
  - addresses 0..128 are each written exactly once with matching data;
  - load_done pulses once.
- load_base=510, load_len=4 -> writes go to 510, 511, 0, 1; load_start during LOAD is ignored; load_len=0 -> load_done pulse with no osd_ram_wen.
- rst asserted at word 50 of 129 -> osd_ram_wen=0 and load_busy=0 immediately, registers return to 0, and no load_done pulse.

Source files
------------

// File: rtl/vip_osd_ctrl.sv
// vip_osd_ctrl
//   Configuration and RAM-load sequencer for vip_osd, running entirely in the
//   pclk domain.
//   - The host writes shadow copies of the OSD window and colour registers at
//     any time. A commit request makes them live atomically on the next vsync
//     rising edge, so the overlay never changes mid-frame.
//   - Glyph bitmap words arrive on a valid/ready stream and are written into
//     the vip_osd RAM port. With LOAD_IN_BLANK set, words are accepted only
//     during vertical blank.
//
// Ports
//   pclk_i, rst_i             pixel clock; asynchronous active-high reset
//   in_vsync_i                frame sync, high = vertical blank
//   cfg_wen_i/addr_i/wdata_i  register write port (0:x 1:y 2:w 3:h 4:fg 5:bg 6:ctrl)
//   load_start_i/base_i/len_i start a RAM load of len words at base (len 0 = no-op)
//   s_valid_i/s_data_i/s_ready_o  glyph word stream
//   load_busy_o, load_done_o  loader status; done pulses with the last write
//   commit_pending_o          shadow registers are waiting for vsync
//   osd_x/y/w/h_o, color_fg/bg_o  active (committed, clamped) window and colours
//   osd_ram_wen/addr/wdata_o  registered RAM write port
module vip_osd_ctrl #(
  parameter int BITS              = 8,
  parameter int WIDTH             = 1280,
  parameter int HEIGHT            = 720,
  parameter int OSD_RAM_ADDR_BITS = 9,
  parameter int OSD_RAM_DATA_BITS = 32,
  parameter int LOAD_IN_BLANK     = 1
) (
  input  logic                         pclk_i,
  input  logic                         rst_i,
  input  logic                         in_vsync_i,
  input  logic                         cfg_wen_i,
  input  logic [2:0]                   cfg_addr_i,
  input  logic [15:0]                  cfg_wdata_i,
  input  logic                         load_start_i,
  input  logic [OSD_RAM_ADDR_BITS-1:0] load_base_i,
  input  logic [OSD_RAM_ADDR_BITS:0]   load_len_i,
  input  logic                         s_valid_i,
  input  logic [OSD_RAM_DATA_BITS-1:0] s_data_i,
  output logic                         s_ready_o,
  output logic                         load_busy_o,
  output logic                         load_done_o,
  output logic                         commit_pending_o,
  output logic [10:0]                  osd_x_o,
  output logic [9:0]                   osd_y_o,
  output logic [10:0]                  osd_w_o,
  output logic [9:0]                   osd_h_o,
  output logic [BITS-1:0]              color_fg_o,
  output logic [BITS-1:0]              color_bg_o,
  output logic                         osd_ram_wen_o,
  output logic [OSD_RAM_ADDR_BITS-1:0] osd_ram_addr_o,
  output logic [OSD_RAM_DATA_BITS-1:0] osd_ram_wdata_o
);

  localparam int AB = OSD_RAM_ADDR_BITS;
  localparam int DB = OSD_RAM_DATA_BITS;
  localparam logic [11:0] WIDTH12  = 12'(WIDTH);
  localparam logic [11:0] HEIGHT12 = 12'(HEIGHT);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} loadState_t;

  logic [10:0]     shadowX_q, shadowW_q;
  logic [9:0]      shadowY_q, shadowH_q;
  logic [BITS-1:0] shadowFg_q, shadowBg_q;
  logic            shadowEn_q;
  logic            commitPending_q, commitPending_d;
  logic            vsyncDly_q, commitGo_q, commitGo_d, commitWr;
  logic [11:0]     wClamp, hClamp;
  logic            unused_cfg_bits;

  loadState_t          state_q, state_d;
  logic [AB-1:0]       addr_q, addr_d, ramAddr_q, ramAddr_d;
  logic [AB:0]         remain_q, remain_d;
  logic [DB-1:0]       ramData_q, ramData_d;
  logic                wen_q, wen_d, done_q, done_d, accept;

  assign unused_cfg_bits = ^cfg_wdata_i[15:11];

  // A ctrl write with bit1 set requests a commit; the bit itself is never stored.
  // The commit decision is registered at the vsync rising edge and the active
  // registers load one cycle later, so writes landing in that commit cycle only
  // reach the shadow copy and wait for the following commit.
  always_comb begin
    commitWr        = cfg_wen_i && (cfg_addr_i == 3'd6) && cfg_wdata_i[1];
    commitGo_d      = in_vsync_i && !vsyncDly_q && (commitPending_q || commitWr);
    commitPending_d = commitPending_q;
    if (commitWr) begin
      commitPending_d = 1'b1;
    end else if (commitGo_q) begin
      commitPending_d = 1'b0;
    end
  end

  // Window size clamp in 12-bit unsigned arithmetic: a window starting off
  // screen collapses to zero, one running past the edge is trimmed to fit,
  // and a disabled OSD is hidden by zeroing both dimensions.
  always_comb begin
    wClamp = {1'b0, shadowW_q};
    hClamp = {2'b00, shadowH_q};
    if (!shadowEn_q || ({1'b0, shadowX_q} >= WIDTH12)) begin
      wClamp = 12'd0;
    end else if (({1'b0, shadowX_q} + {1'b0, shadowW_q}) > WIDTH12) begin
      wClamp = WIDTH12 - {1'b0, shadowX_q};
    end
    if (!shadowEn_q || ({2'b00, shadowY_q} >= HEIGHT12)) begin
      hClamp = 12'd0;
    end else if (({2'b00, shadowY_q} + {2'b00, shadowH_q}) > HEIGHT12) begin
      hClamp = HEIGHT12 - {2'b00, shadowY_q};
    end
  end

  // Shadow registers, vsync edge tracking and the committed (active) copy.
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      shadowX_q       <= '0;
      shadowY_q       <= '0;
      shadowW_q       <= '0;
      shadowH_q       <= '0;
      shadowFg_q      <= '0;
      shadowBg_q      <= '0;
      shadowEn_q      <= 1'b0;
      commitPending_q <= 1'b0;
      vsyncDly_q      <= 1'b0;
      commitGo_q      <= 1'b0;
      osd_x_o         <= '0;
      osd_y_o         <= '0;
      osd_w_o         <= '0;
      osd_h_o         <= '0;
      color_fg_o      <= '0;
      color_bg_o      <= '0;
    end else begin
      vsyncDly_q      <= in_vsync_i;
      commitGo_q      <= commitGo_d;
      commitPending_q <= commitPending_d;
      if (cfg_wen_i) begin
        case (cfg_addr_i)
          3'd0:    shadowX_q  <= cfg_wdata_i[10:0];
          3'd1:    shadowY_q  <= cfg_wdata_i[9:0];
          3'd2:    shadowW_q  <= cfg_wdata_i[10:0];
          3'd3:    shadowH_q  <= cfg_wdata_i[9:0];
          3'd4:    shadowFg_q <= cfg_wdata_i[BITS-1:0];
          3'd5:    shadowBg_q <= cfg_wdata_i[BITS-1:0];
          3'd6:    shadowEn_q <= cfg_wdata_i[0];
          default: ;
        endcase
      end
      if (commitGo_q) begin
        osd_x_o    <= shadowX_q;
        osd_y_o    <= shadowY_q;
        osd_w_o    <= 11'(wClamp);
        osd_h_o    <= 10'(hClamp);
        color_fg_o <= shadowFg_q;
        color_bg_o <= shadowBg_q;
      end
    end
  end

  assign commit_pending_o = commitPending_q;

  // Loader handshake: the source is only offered a slot during a load, and
  // only in vertical blank when blank gating is on.
  assign s_ready_o   = (state_q == LOAD) && ((LOAD_IN_BLANK != 0) ? in_vsync_i : 1'b1);
  assign accept      = s_ready_o && s_valid_i;
  assign load_busy_o = (state_q == LOAD);
  assign load_done_o = done_q;

  // Loader next-state logic. Each accepted word becomes a registered RAM write
  // on the following cycle; the address wraps naturally at the RAM size.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    wen_d     = 1'b0;
    ramAddr_d = ramAddr_q;
    ramData_d = ramData_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          if (load_len_i != '0) begin
            state_d  = LOAD;
            addr_d   = load_base_i;
            remain_d = load_len_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wen_d     = 1'b1;
          ramAddr_d = addr_q;
          ramData_d = s_data_i;
          addr_d    = addr_q + AB'(1);
          remain_d  = remain_q - (AB+1)'(1);
          if (remain_q == (AB+1)'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Loader state and registered RAM write port.
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      wen_q     <= 1'b0;
      ramAddr_q <= '0;
      ramData_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      wen_q     <= wen_d;
      ramAddr_q <= ramAddr_d;
      ramData_q <= ramData_d;
      done_q    <= done_d;
    end
  end

  assign osd_ram_wen_o   = wen_q;
  assign osd_ram_addr_o  = ramAddr_q;
  assign osd_ram_wdata_o = ramData_q;

endmodule

// File: tb/tb_vip_osd_ctrl.sv
// tb_vip_osd_ctrl
//   Self-checking bench for vip_osd_ctrl. A frame-level model tracks the host's
//   shadow writes and commit requests and predicts the committed window after
//   each vsync; a scoreboard predicts every RAM write from the load base and
//   the glyph words the bench itself supplies.
module tb_vip_osd_ctrl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        inVsync, cfgWen, loadStart, sValid;
  logic [2:0]  cfgAddr;
  logic [15:0] cfgWdata;
  logic [8:0]  loadBase;
  logic [9:0]  loadLen;
  logic [31:0] sData;
  logic        sReady, loadBusy, loadDone, commitPending, ramWen;
  logic [10:0] osdX, osdW;
  logic [9:0]  osdY, osdH;
  logic [7:0]  colorFg, colorBg;
  logic [8:0]  ramAddr;
  logic [31:0] ramWdata;

  int passCount = 0;
  int checkCount = 0;

  // Frame-level model state
  int shX = 0, shY = 0, shW = 0, shH = 0, shFg = 0, shBg = 0;
  bit shEn = 0;
  int snapX = 0, snapY = 0, snapW = 0, snapH = 0, snapFg = 0, snapBg = 0;
  bit snapEn = 0;
  bit pend = 0, sched = 0, vsPrev = 0;
  int expX = 0, expY = 0, expW = 0, expH = 0, expFg = 0, expBg = 0;

  // Loader scoreboard state
  int srcIdx = 0, wrIdx = 0, doneCnt = 0, expBase = 0;
  int hits[512];

  vip_osd_ctrl dut (
    .pclk_i(pclk), .rst_i(rst), .in_vsync_i(inVsync),
    .cfg_wen_i(cfgWen), .cfg_addr_i(cfgAddr), .cfg_wdata_i(cfgWdata),
    .load_start_i(loadStart), .load_base_i(loadBase), .load_len_i(loadLen),
    .s_valid_i(sValid), .s_data_i(sData), .s_ready_o(sReady),
    .load_busy_o(loadBusy), .load_done_o(loadDone), .commit_pending_o(commitPending),
    .osd_x_o(osdX), .osd_y_o(osdY), .osd_w_o(osdW), .osd_h_o(osdH),
    .color_fg_o(colorFg), .color_bg_o(colorBg),
    .osd_ram_wen_o(ramWen), .osd_ram_addr_o(ramAddr), .osd_ram_wdata_o(ramWdata)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] glyphWord(input int n);
    logic [31:0] v;
    v = 32'h5A00_00FF ^ (n * 32'h0001_0203);
    return v;
  endfunction

  // Visible length of a window span after clipping to the frame
  function automatic int clampLen(input int pos, input int len, input int lim, input bit en);
    if (!en || pos >= lim) return 0;
    if (pos + len > lim) return lim - pos;
    return len;
  endfunction

  // Model: a commit request seen at a vsync rising edge snapshots the shadow
  // registers there and makes them visible one cycle later.
  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      shX = 0; shY = 0; shW = 0; shH = 0; shFg = 0; shBg = 0; shEn = 0;
      pend = 0; sched = 0; vsPrev = 0;
      expX = 0; expY = 0; expW = 0; expH = 0; expFg = 0; expBg = 0;
    end else begin
      bit cw, pendBefore, go;
      cw = cfgWen && cfgAddr == 3'd6 && cfgWdata[1];
      pendBefore = pend;
      go = sched;
      sched = 0;
      if (go) begin
        expX = snapX; expY = snapY; expFg = snapFg; expBg = snapBg;
        expW = clampLen(snapX, snapW, 1280, snapEn);
        expH = clampLen(snapY, snapH, 720, snapEn);
      end
      if (cfgWen) begin
        case (cfgAddr)
          3'd0: shX = cfgWdata % 2048;
          3'd1: shY = cfgWdata % 1024;
          3'd2: shW = cfgWdata % 2048;
          3'd3: shH = cfgWdata % 1024;
          3'd4: shFg = cfgWdata % 256;
          3'd5: shBg = cfgWdata % 256;
          3'd6: shEn = cfgWdata[0];
          default: ;
        endcase
      end
      if (cw) pend = 1;
      else if (go) pend = 0;
      if (inVsync && !vsPrev && (pendBefore || cw)) begin
        sched = 1;
        snapX = shX; snapY = shY; snapW = shW; snapH = shH;
        snapFg = shFg; snapBg = shBg; snapEn = shEn;
      end
      checkOutput("s_ready_gate", {31'b0, sReady & ~inVsync}, 0);
      if (sValid && sReady) srcIdx++;
      vsPrev = inVsync;
    end
  end

  // Compare process: committed registers every cycle, RAM writes as they occur
  always @(negedge pclk) begin
    if (!rst) begin
      checkOutput("osd_x", osdX, expX);
      checkOutput("osd_y", osdY, expY);
      checkOutput("osd_w", osdW, expW);
      checkOutput("osd_h", osdH, expH);
      checkOutput("color_fg", colorFg, expFg);
      checkOutput("color_bg", colorBg, expBg);
      checkOutput("commit_pending", commitPending, pend);
      if (ramWen) begin
        checkOutput("ram_in_blank", vsPrev, 1);
        checkOutput("ram_addr", ramAddr, (expBase + wrIdx) % 512);
        checkOutput("ram_data", ramWdata, glyphWord(wrIdx));
        hits[ramAddr]++;
        wrIdx++;
      end
      if (loadDone) doneCnt++;
    end
  end

  // Source data follows the number of words accepted so far
  initial begin
    sData = '0;
    forever begin
      @(negedge pclk);
      sData = glyphWord(srcIdx);
    end
  end

  task automatic applyStimulus(input int addr, input int data);
    @(negedge pclk);
    cfgWen = 1'b1;
    cfgAddr = 3'(addr);
    cfgWdata = 16'(data);
    @(negedge pclk);
    cfgWen = 1'b0;
  endtask

  task automatic startLoad(input int base, input int len);
    loadBase = 9'(base);
    loadLen = 10'(len);
    loadStart = 1'b1;
    @(negedge pclk);
    loadStart = 1'b0;
  endtask

  task automatic clearScoreboard(input int base);
    srcIdx = 0; wrIdx = 0; doneCnt = 0; expBase = base;
    foreach (hits[i]) hits[i] = 0;
  endtask

  task automatic vsyncRise();
    inVsync = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  task automatic vsyncEnd();
    repeat (2) @(negedge pclk);
    inVsync = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  task automatic waitDone(input int budget);
    for (int c = 0; c < budget && doneCnt == 0; c++) @(negedge pclk);
  endtask

  initial begin
    int bad;
    rst = 1'b1; inVsync = 1'b0; cfgWen = 1'b0; cfgAddr = '0; cfgWdata = '0;
    loadStart = 1'b0; loadBase = '0; loadLen = '0; sValid = 1'b0;
    repeat (3) @(negedge pclk);
    checkOutput("rst_osd_x", osdX, 0);
    checkOutput("rst_pending", commitPending, 0);
    checkOutput("rst_s_ready", sReady, 0);
    checkOutput("rst_busy", loadBusy, 0);
    checkOutput("rst_done", loadDone, 0);
    checkOutput("rst_ram_wen", ramWen, 0);
    checkOutput("rst_ram_addr", ramAddr, 0);
    checkOutput("rst_ram_wdata", ramWdata, 0);
    rst = 1'b0;

    // Basic commit: nothing visible until vsync, then two cycles later
    applyStimulus(0, 100); applyStimulus(1, 100); applyStimulus(2, 128);
    applyStimulus(3, 32); applyStimulus(4, 'hFF); applyStimulus(5, 0);
    applyStimulus(6, 3);
    checkOutput("t1_x_before_vsync", osdX, 0);
    checkOutput("t1_pending_set", commitPending, 1);
    inVsync = 1'b1;
    @(negedge pclk);
    checkOutput("t1_x_one_cycle", osdX, 0);
    @(negedge pclk);
    checkOutput("t1_x", osdX, 100);
    checkOutput("t1_w", osdW, 128);
    checkOutput("t1_h", osdH, 32);
    checkOutput("t1_fg", colorFg, 'hFF);
    checkOutput("t1_pending_clear", commitPending, 0);
    vsyncEnd();

    // Clipping at the right and bottom edges
    applyStimulus(0, 1200); applyStimulus(6, 3);
    vsyncRise(); checkOutput("t2_w_trim", osdW, 80); vsyncEnd();
    applyStimulus(0, 1280); applyStimulus(6, 3);
    vsyncRise(); checkOutput("t2_w_offscreen", osdW, 0); vsyncEnd();
    applyStimulus(0, 100); applyStimulus(1, 700); applyStimulus(6, 3);
    vsyncRise(); checkOutput("t2_h_trim", osdH, 20); checkOutput("t2_w_full", osdW, 128); vsyncEnd();

    // Disabled OSD hides the window but still moves it
    applyStimulus(0, 300); applyStimulus(2, 128); applyStimulus(6, 2);
    vsyncRise();
    checkOutput("t3_w_hidden", osdW, 0);
    checkOutput("t3_h_hidden", osdH, 0);
    checkOutput("t3_x", osdX, 300);
    vsyncEnd();

    // 129-word load gated to vertical blank
    clearScoreboard(0);
    startLoad(0, 129);
    sValid = 1'b1;
    for (int cyc = 0; cyc < 6000 && doneCnt == 0; cyc++) begin
      inVsync = (cyc % 60) >= 20;
      @(negedge pclk);
    end
    inVsync = 1'b0;
    sValid = 1'b0;
    repeat (3) @(negedge pclk);
    checkOutput("t4_done_count", doneCnt, 1);
    checkOutput("t4_write_count", wrIdx, 129);
    bad = 0;
    for (int a = 0; a < 512; a++) if (hits[a] != ((a <= 128) ? 1 : 0)) bad++;
    checkOutput("t4_each_addr_once", bad, 0);

    // Address wrap, and a start request during a load is ignored
    inVsync = 1'b1;
    clearScoreboard(510);
    startLoad(510, 4);
    sValid = 1'b1;
    checkOutput("t5_busy", loadBusy, 1);
    startLoad(100, 7);
    waitDone(100);
    repeat (20) @(negedge pclk);
    sValid = 1'b0;
    checkOutput("t5_write_count", wrIdx, 4);
    checkOutput("t5_done_count", doneCnt, 1);
    checkOutput("t5_hit_510", hits[510], 1);
    checkOutput("t5_hit_511", hits[511], 1);
    checkOutput("t5_hit_0", hits[0], 1);
    checkOutput("t5_hit_1", hits[1], 1);

    // Zero-length load just pulses done
    clearScoreboard(0);
    startLoad(5, 0);
    repeat (4) @(negedge pclk);
    checkOutput("t5_zero_done", doneCnt, 1);
    checkOutput("t5_zero_writes", wrIdx, 0);

    // Reset in the middle of a load
    applyStimulus(6, 2);
    clearScoreboard(0);
    startLoad(0, 129);
    sValid = 1'b1;
    for (int c = 0; c < 400 && srcIdx < 50; c++) @(negedge pclk);
    checkOutput("t6_reached_word50", srcIdx, 50);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_ram_wen", ramWen, 0);
    checkOutput("t6_busy", loadBusy, 0);
    checkOutput("t6_s_ready", sReady, 0);
    checkOutput("t6_ram_addr", ramAddr, 0);
    checkOutput("t6_osd_x", osdX, 0);
    checkOutput("t6_pending", commitPending, 0);
    sValid = 1'b0;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    repeat (20) @(negedge pclk);
    checkOutput("t6_no_done", doneCnt, 0);
    checkOutput("t6_idle", loadBusy, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
